// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions for the RS-decoder multiplier arbiter.
// Holds default field parameters and a reference multiply function.
package gf_pkg;

    localparam int SYMB_WIDTH = 8;
    localparam int POLY       = 285;

    typedef logic [SYMB_WIDTH-1:0] symb_t;

    localparam symb_t POLY_FB = symb_t'(POLY);

    // Interleaved shift-and-XOR multiply: scale A by x each step, reduce on overflow.
    function automatic symb_t gf_mul_ref(input symb_t a, input symb_t b);
        symb_t p;
        symb_t x;
        symb_t bb;
        p  = '0;
        x  = a;
        bb = b;
        for (int unsigned i = 0; i < SYMB_WIDTH; i++) begin
            if (bb[0]) p = p ^ x;
            if (x[SYMB_WIDTH-1]) x = (x << 1) ^ POLY_FB;
            else                 x = x << 1;
            bb = bb >> 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/gf_mult.sv
// Combinational GF(2^SYMB_WIDTH) multiplier.
// Full carry-less product first, then polynomial reduction from the top bit down.
module gf_mult
    import gf_pkg::*;
#(
    parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH,
    parameter int POLY       = gf_pkg::POLY
) (
    input  logic [SYMB_WIDTH-1:0] a,
    input  logic [SYMB_WIDTH-1:0] b,
    output logic [SYMB_WIDTH-1:0] p
);

    localparam int FULL_W = 2 * SYMB_WIDTH - 1;
    localparam logic [SYMB_WIDTH-1:0] FB = SYMB_WIDTH'(POLY);

    logic [FULL_W-1:0] full;

    always_comb begin
        full = '0;
        for (int unsigned i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) full = full ^ (FULL_W'(a) << i);
        end
        // Fold each bit above the field degree back in, highest first.
        for (int unsigned k = 0; k < SYMB_WIDTH - 1; k++) begin
            if (|(full & (FULL_W'(1) << (SYMB_WIDTH + (SYMB_WIDTH - 2 - k)))))
                full = full ^ (FULL_W'(FB) << (SYMB_WIDTH - 2 - k));
        end
        p = full[SYMB_WIDTH-1:0];
    end

endmodule

// File: rtl/gf_mult_arbiter.sv
// Round-robin arbiter sharing one GF multiplier between N_REQ requesters,
// with a two-stage registered pipeline and full valid/ready backpressure.
module gf_mult_arbiter
    import gf_pkg::*;
#(
    parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH,
    parameter int POLY       = gf_pkg::POLY,
    parameter int N_REQ      = 4,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*SYMB_WIDTH-1:0] req_a,
    input  logic [N_REQ*SYMB_WIDTH-1:0] req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [SYMB_WIDTH-1:0]       rsp_p,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        busy
);

    logic [SYMB_WIDTH-1:0] a_arr [N_REQ];
    logic [SYMB_WIDTH-1:0] b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*SYMB_WIDTH +: SYMB_WIDTH];
        assign b_arr[g] = req_b[g*SYMB_WIDTH +: SYMB_WIDTH];
    end

    logic                  s1_vld;
    logic [SYMB_WIDTH-1:0] s1_a;
    logic [SYMB_WIDTH-1:0] s1_b;
    logic [ID_W-1:0]       s1_id;
    logic                  s2_vld;
    logic [SYMB_WIDTH-1:0] s2_p;
    logic [ID_W-1:0]       s2_id;
    logic [ID_W-1:0]       last_gnt;

    logic                  s1_adv;
    logic                  s2_adv;
    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       gnt_idx;
    logic [ID_W-1:0]       scan_idx;
    logic                  found;
    logic                  accept;
    logic [SYMB_WIDTH-1:0] prod;

    assign s2_adv = !s2_vld || rsp_ready;
    assign s1_adv = !s1_vld || s2_adv;

    // Scan starts one past the last accepted requester and wraps.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = ID_W'((32'(last_gnt) + 32'd1 + k) % 32'(N_REQ));
            if (!found && req_valid[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (found) grant[gnt_idx] = 1'b1;
        accept    = found && s1_adv && !rst;
        req_ready = accept ? grant : '0;
    end

    gf_mult #(
        .SYMB_WIDTH(SYMB_WIDTH),
        .POLY      (POLY)
    ) u_gf_mult (
        .a(s1_a),
        .b(s1_b),
        .p(prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_vld   <= 1'b0;
            s2_p     <= '0;
            s2_id    <= '0;
            last_gnt <= ID_W'(N_REQ - 1);
        end else begin
            if (s1_adv) begin
                s1_vld <= accept;
                if (accept) begin
                    s1_a     <= a_arr[gnt_idx];
                    s1_b     <= b_arr[gnt_idx];
                    s1_id    <= gnt_idx;
                    last_gnt <= gnt_idx;
                end
            end
            // Payload only moves on a real handover; an empty advance just clears valid.
            if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_p  <= prod;
                    s2_id <= s1_id;
                end
            end
        end
    end

    assign rsp_valid = s2_vld;
    assign rsp_p     = s2_p;
    assign rsp_id    = s2_id;
    assign busy      = s1_vld || s2_vld;

endmodule

// File: tb/tb_gf_mult_arbiter.sv
// Self-checking bench for gf_mult_arbiter: directed vectors, backpressure/reset
// sequences and a randomized run against a queue-based reference model.
module tb_gf_mult_arbiter;
    import gf_pkg::*;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_p;
    logic [IDW-1:0] rsp_id;
    logic           busy;

    gf_mult_arbiter #(
        .SYMB_WIDTH(W),
        .POLY      (285),
        .N_REQ     (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_p    (rsp_p),
        .rsp_id   (rsp_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input symb_t a, input symb_t b);
        req_valid[i]       = v;
        req_a[i*W +: W]    = a;
        req_b[i*W +: W]    = b;
    endtask

    function automatic symb_t op_a(input int i);
        return symb_t'(8'h11 * (i + 1));
    endfunction
    function automatic symb_t op_b(input int i);
        return symb_t'(8'h35 + i);
    endfunction

    task automatic all_valid();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, op_a(i), op_b(i));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference model state
    symb_t        exp_q [N][$];
    int           inflight;
    int           last_acc;
    logic         prev_stall;
    symb_t        prev_p;
    logic [IDW-1:0] prev_id;
    logic [N-1:0] acc;

    task automatic model_reset();
        for (int i = 0; i < N; i++) exp_q[i].delete();
        inflight   = 0;
        last_acc   = N - 1;
        prev_stall = 1'b0;
        acc        = '0;
    endtask

    // Called at negedge: predicts ready from round-robin rule and pipeline occupancy.
    task automatic monitor();
        int pick;
        logic allowed;
        logic [N-1:0] exp_ready;
        symb_t e;
        pick = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last_acc + k) % N;
            if (pick < 0 && req_valid[j]) pick = j;
        end
        allowed   = !(inflight == 2 && !rsp_ready);
        exp_ready = (pick >= 0 && allowed) ? N'(1) << pick : '0;
        check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
        check("rnd_busy", 32'(busy), 32'(inflight != 0));
        if (prev_stall)
            check("rnd_stall_hold", {21'd0, rsp_valid, rsp_id, rsp_p}, {21'd0, 1'b1, prev_id, prev_p});
        if (rsp_valid && rsp_ready) begin
            if (exp_q[rsp_id].size() == 0) begin
                n_chk++;
                $display("FAIL rnd_rsp_unexpected: got id %0d p 0x%0h expected no response", rsp_id, rsp_p);
            end else begin
                e = exp_q[rsp_id].pop_front();
                check("rnd_rsp_p", 32'(rsp_p), 32'(e));
            end
            inflight--;
        end
        acc = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                exp_q[i].push_back(gf_mul_ref(req_a[i*W +: W], req_b[i*W +: W]));
                inflight++;
                last_acc = i;
            end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_p     = rsp_p;
        prev_id    = rsp_id;
    endtask

    function automatic symb_t rnd_op();
        return ($urandom_range(0, 7) == 0) ? symb_t'(0) : symb_t'($urandom);
    endfunction

    typedef struct {
        int    id;
        symb_t a;
        symb_t b;
        symb_t p;
    } vec_t;

    vec_t vecs [8];
    int   seen [$];
    int   acc_cnt;
    symb_t p0;
    int   left;

    initial begin
        vecs[0] = '{1, 8'h02, 8'h80, 8'h1D};
        vecs[1] = '{0, 8'h00, 8'h53, 8'h00};
        vecs[2] = '{2, 8'h01, 8'hAB, 8'hAB};
        vecs[3] = '{3, 8'h8E, 8'h02, 8'h01};
        vecs[4] = '{1, 8'h80, 8'h80, 8'h13};
        vecs[5] = '{2, 8'h03, 8'h03, 8'h05};
        vecs[6] = '{0, 8'h53, 8'h00, 8'h00};
        vecs[7] = '{3, 8'hFF, 8'h01, 8'hFF};

        req_a = '0;
        req_b = '0;
        do_reset();
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_p", 32'(rsp_p), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        tick();

        // Single requests with exact two-cycle latency
        rsp_ready = 1'b1;
        foreach (vecs[v]) begin
            req_valid = '0;
            set_req(vecs[v].id, 1'b1, vecs[v].a, vecs[v].b);
            @(negedge clk);
            check("vec_ready", 32'(req_ready), 32'(N'(1) << vecs[v].id));
            tick();
            req_valid = '0;
            @(negedge clk);
            check("vec_lat_early", 32'(rsp_valid), 32'd0);
            tick();
            @(negedge clk);
            check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            check("vec_rsp_p", 32'(rsp_p), 32'(vecs[v].p));
            check("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
            tick();
        end

        // All requesters valid, full rate
        do_reset();
        all_valid();
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(N'(1) << (k % N)));
            if (k >= 2) begin
                check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                check("rr_rsp_id", 32'(rsp_id), 32'((k - 2) % N));
                check("rr_rsp_p", 32'(rsp_p), 32'(gf_mul_ref(op_a((k - 2) % N), op_b((k - 2) % N))));
            end
            tick();
        end

        // Backpressure for 5 cycles
        do_reset();
        all_valid();
        rsp_ready = 1'b0;
        acc_cnt   = 0;
        p0        = gf_mul_ref(op_a(0), op_b(0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acc_cnt += $countones(req_ready & req_valid);
            if (k >= 2) begin
                check("bp_ready_zero", 32'(req_ready), 32'd0);
                check("bp_hold", {23'd0, rsp_valid, rsp_id, rsp_p}, {23'd0, 1'b1, 2'd0, p0});
            end
            tick();
        end
        check("bp_accepts", 32'(acc_cnt), 32'd2);
        rsp_ready = 1'b1;
        seen.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) seen.push_back(int'(rsp_id));
            tick();
        end
        check("bp_rsp_count", 32'(seen.size()), 32'd8);
        foreach (seen[j]) check("bp_rsp_order", 32'(seen[j]), 32'(j % N));

        // Reset with both stages full
        do_reset();
        all_valid();
        rsp_ready = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        check("rf_full_busy", 32'(busy), 32'd1);
        check("rf_full_valid", 32'(rsp_valid), 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rf_ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rf_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rf_busy", 32'(busy), 32'd0);
        check("rf_rsp_p", 32'(rsp_p), 32'd0);
        check("rf_rsp_id", 32'(rsp_id), 32'd0);
        check("rf_first_grant", 32'(req_ready), 32'd1);
        tick();

        // Randomized run against the queue model
        do_reset();
        model_reset();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            monitor();
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !req_valid[i])
                    set_req(i, 1'($urandom_range(0, 1)), rnd_op(), rnd_op());
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            monitor();
            tick();
            for (int i = 0; i < N; i++) if (acc[i]) req_valid[i] = 1'b0;
        end
        left = 0;
        for (int i = 0; i < N; i++) left += exp_q[i].size();
        check("rnd_drain_left", 32'(left), 32'd0);
        check("rnd_drain_valid", 32'(req_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
